riscv_mul_pipe: RTL
===================

RISCV_MUL_PIPE -- requirements
Module: riscv_mul_pipe

Interface
REQ-001 SHALL have parameter STAGES, default 2, meaning pipeline depth in cycles from accept to result (legal range 1..4).
REQ-002 SHALL have parameter SUPPORT_MULH, default 1, meaning MULH/MULHSU/MULHU are decoded when 1; when 0 only MUL is decoded.
REQ-003 SHALL have port clk_i  input  1  clock.
REQ-004 SHALL have port rst_i  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 SHALL have port opcode_valid_i  input  1  issue slot holds an instruction.
REQ-006 SHALL have port opcode_opcode_i  input  32  raw instruction word.
REQ-007 SHALL have port opcode_invalid_i  input  1  instruction faulted upstream; do not execute.
REQ-008 SHALL have port opcode_rd_idx_i  input  5  destination register.
REQ-009 SHALL have ports opcode_ra_operand_i and opcode_rb_operand_i  input  32  rs1/rs2 values.
REQ-010 SHALL have port hold_i  input  1  pipeline stall.
REQ-011 SHALL have port flush_i  input  1  kill all in-flight and incoming operations.
REQ-012 SHALL have port writeback_valid_o  output  1  final-stage result valid.
REQ-013 SHALL have port writeback_rd_idx_o  output  5  destination tag of the result.
REQ-014 SHALL have port writeback_value_o  output  32  result data.

Function
REQ-015 SHALL decode opcode 0110011 with funct7 0000001 and funct3 000/001/010/011 as MUL/MULH/MULHSU/MULHU; all other words are not accepted.
REQ-016 SHALL accept an operation in a cycle when opcode_valid_i=1, opcode_invalid_i=0, decode hit, hold_i=0 and flush_i=0.
REQ-017 SHALL extend operands to 33 bits: rs1 sign-extended for MULH/MULHSU, rs2 sign-extended for MULH, otherwise zero-extended; form the 66-bit signed product.
REQ-018 SHALL return product[31:0] for MUL and product[63:32] for MULH/MULHSU/MULHU.
REQ-019 SHALL assert writeback_valid_o exactly STAGES rising edges after accept when hold_i stays low, with matching writeback_rd_idx_o.
REQ-020 SHALL sustain one accept per cycle; results leave in issue order with no bubbles inserted.
REQ-021 SHALL freeze every stage (valid, tag, data) while hold_i=1; outputs remain stable and latency extends by the number of held cycles.
REQ-022 SHALL clear every stage valid bit on the edge where flush_i=1, taking priority over hold_i and accept.
REQ-023 SHALL drive writeback_value_o and writeback_rd_idx_o to 0 whenever writeback_valid_o=0.
REQ-024 SHALL treat rd=0 as an ordinary tag; suppression of x0 writes belongs to the register file.

Reset
REQ-025 SHALL, on rst_i=1 at a rising edge, clear all stage valid bits, tags and data; writeback_valid_o=0, writeback_rd_idx_o=0, writeback_value_o=0 the following cycle.
REQ-026 SHALL give rst_i priority over flush_i, hold_i and accept; an operation in flight at reset is discarded.

Structure
REQ-027 SHALL take the RV32M opcode/mask constants (INST_MUL, INST_MULH, INST_MULHSU, INST_MULHU and masks) from riscv_defs.v, adding them there if missing.
REQ-028 SHALL implement one pipeline register slice (valid, rd tag, payload, hold/flush/reset handling) as sub-module riscv_mul_stage, instantiated by generate loop; the multiply itself sits in stage 1.

Verification
REQ-029 SHALL cover: MUL ra=7, rb=0xFFFFFFFD, STAGES=2 -> valid two cycles later, value 0xFFFFFFEB, rd tag preserved.
REQ-030 SHALL cover: ra=rb=0x80000000 as MULH -> 0x40000000; as MULHU -> 0x40000000; MULHSU ra=rb=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 SHALL cover: four back-to-back MULs (rd 1..4, products 2,6,12,20) -> four consecutive valid cycles in order, correct tags.
REQ-032 SHALL cover: accept at cycle 0, hold_i high cycles 1-3 -> valid first appears at cycle STAGES+3, outputs stable during hold.
REQ-033 SHALL cover: two ops in flight, flush_i one cycle -> no writeback_valid_o; next op after flush completes normally.
REQ-034 SHALL cover: rst_i asserted one cycle mid-operation, plus opcode_invalid_i=1 or non-M opcode (ADD) -> no valid output, all outputs 0.

Source files
------------

// File: rtl/riscv_mul_pipe_pkg.sv
// RV32M multiply decode constants, operation encoding and the shared
// decode/product helpers used by the multiply pipeline.
package riscv_mul_pipe_pkg;

  localparam logic [31:0] INST_MUL         = 32'h02000033;
  localparam logic [31:0] INST_MUL_MASK    = 32'hfe00707f;
  localparam logic [31:0] INST_MULH        = 32'h02001033;
  localparam logic [31:0] INST_MULH_MASK   = 32'hfe00707f;
  localparam logic [31:0] INST_MULHSU      = 32'h02002033;
  localparam logic [31:0] INST_MULHSU_MASK = 32'hfe00707f;
  localparam logic [31:0] INST_MULHU       = 32'h02003033;
  localparam logic [31:0] INST_MULHU_MASK  = 32'hfe00707f;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } mul_op_e;

  typedef struct packed {
    logic    hit;
    mul_op_e op;
  } mul_dec_t;

  function automatic mul_dec_t mul_decode(input logic [31:0] insn, input logic en_mulh);
    mul_dec_t d;
    d.hit = 1'b0;
    d.op  = OP_MUL;
    if ((insn & INST_MUL_MASK) == INST_MUL) begin
      d.hit = 1'b1;
    end else if (en_mulh) begin
      if ((insn & INST_MULH_MASK) == INST_MULH) begin
        d.hit = 1'b1;
        d.op  = OP_MULH;
      end else if ((insn & INST_MULHSU_MASK) == INST_MULHSU) begin
        d.hit = 1'b1;
        d.op  = OP_MULHSU;
      end else if ((insn & INST_MULHU_MASK) == INST_MULHU) begin
        d.hit = 1'b1;
        d.op  = OP_MULHU;
      end
    end
    return d;
  endfunction

  // Low 64 bits of the 33x33 signed product equal the 64x64 product of the
  // sign/zero-extended operands, so a plain 64-bit multiply suffices.
  function automatic logic [XLEN-1:0] mul_result(input mul_op_e op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic        sa, sb;
    logic [63:0] ax, bx, p;
    sa = (op == OP_MULH) || (op == OP_MULHSU);
    sb = (op == OP_MULH);
    ax = {{32{sa & a[31]}}, a};
    bx = {{32{sb & b[31]}}, b};
    p  = ax * bx;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

endpackage

// File: rtl/riscv_mul_stage.sv
// One pipeline register slice: valid, destination tag and payload with
// reset > flush > hold priority.
module riscv_mul_stage
  import riscv_mul_pipe_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            hold_i,
  input  logic            flush_i,
  input  logic            vld_i,
  input  logic [RW-1:0]   rd_i,
  input  logic [XLEN-1:0] dat_i,
  output logic            vld_o,
  output logic [RW-1:0]   rd_o,
  output logic [XLEN-1:0] dat_o
);

  logic            vld_q, vld_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    rd_d  = rd_q;
    dat_d = dat_q;
    if (flush_i) begin
      vld_d = 1'b0;
      rd_d  = '0;
      dat_d = '0;
    end else if (!hold_i) begin
      vld_d = vld_i;
      rd_d  = rd_i;
      dat_d = dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
      rd_q  <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      rd_q  <= rd_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign rd_o  = rd_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/riscv_mul_pipe.sv
// RV32M multiply unit: decode and multiply feed stage 1, remaining stages
// just carry the result so writeback lands STAGES edges after accept.
module riscv_mul_pipe
  import riscv_mul_pipe_pkg::*;
#(
  parameter int STAGES       = 2,
  parameter int SUPPORT_MULH = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            opcode_valid_i,
  input  logic [31:0]     opcode_opcode_i,
  input  logic            opcode_invalid_i,
  input  logic [4:0]      opcode_rd_idx_i,
  input  logic [31:0]     opcode_ra_operand_i,
  input  logic [31:0]     opcode_rb_operand_i,
  input  logic            hold_i,
  input  logic            flush_i,
  output logic            writeback_valid_o,
  output logic [4:0]      writeback_rd_idx_o,
  output logic [31:0]     writeback_value_o
);

  mul_dec_t dec;
  logic     accept;

  logic [STAGES:0]           vld_pipe;
  logic [STAGES:0][RW-1:0]   rd_pipe;
  logic [STAGES:0][XLEN-1:0] dat_pipe;

  assign dec    = mul_decode(opcode_opcode_i, SUPPORT_MULH != 0);
  assign accept = opcode_valid_i & ~opcode_invalid_i & dec.hit & ~hold_i & ~flush_i;

  // Non-accepted slots enter as zeros so idle stages never carry stale data.
  assign vld_pipe[0] = accept;
  assign rd_pipe[0]  = accept ? opcode_rd_idx_i : '0;
  assign dat_pipe[0] = accept ? mul_result(dec.op, opcode_ra_operand_i, opcode_rb_operand_i) : '0;

  for (genvar i = 1; i <= STAGES; i++) begin : g_stage
    riscv_mul_stage u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .hold_i  (hold_i),
      .flush_i (flush_i),
      .vld_i   (vld_pipe[i-1]),
      .rd_i    (rd_pipe[i-1]),
      .dat_i   (dat_pipe[i-1]),
      .vld_o   (vld_pipe[i]),
      .rd_o    (rd_pipe[i]),
      .dat_o   (dat_pipe[i])
    );
  end

  assign writeback_valid_o  = vld_pipe[STAGES];
  assign writeback_rd_idx_o = vld_pipe[STAGES] ? rd_pipe[STAGES]  : '0;
  assign writeback_value_o  = vld_pipe[STAGES] ? dat_pipe[STAGES] : '0;

endmodule
